// File: rtl/enemy_bullet_ctrl.sv
// enemy_bullet_ctrl
// Fires one bullet downward from the enemy position, advances it STEP rows per
// frame tick and tests it against the player hitbox. Hit and bottom events are
// one-cycle pulses. The draw FSM reads bulletX / bulletY / active.
//
// Optional feature: define ENEMY_BULLET_AIM_EN to make the bullet drift one
// column per flight tick toward playerX. Without it, bulletX is fixed per shot.
//
// STEP must not exceed HIT_H. A larger step could carry the bullet past the
// whole hitbox in a single tick.

module enemy_bullet_ctrl #(
  parameter int unsigned STEP     = 4,
  parameter int unsigned PLAYER_Y = 100,
  parameter int unsigned HIT_W    = 8,
  parameter int unsigned HIT_H    = 8,
  parameter int unsigned Y_BOTTOM = 119,
  parameter int unsigned COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       enable,
  input  logic [7:0] enemyX,
  input  logic [6:0] enemyY,
  input  logic [7:0] playerX,
  output logic [7:0] bulletX,
  output logic [6:0] bulletY,
  output logic       active,
  output logic       playerHit,
  output logic       bottomReached
);

  // The cooldown counter is only as wide as COOLDOWN requires.
  localparam int unsigned CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  // Constants pre-sized to the widths of the arithmetic they feed.
  localparam logic [7:0]       STEP_8     = 8'(STEP);
  localparam logic [7:0]       SPAWN_OFS  = 8'd8;
  localparam logic [7:0]       Y_BOT_8    = 8'(Y_BOTTOM);
  localparam logic [8:0]       BOX_TOP_9  = 9'(PLAYER_Y);
  localparam logic [8:0]       BOX_BOT_9  = 9'(PLAYER_Y + HIT_H);
  localparam logic [8:0]       HIT_W_9    = 9'(HIT_W);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(COOLDOWN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COOL   = 2'd1,
    S_FLIGHT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       x_q,     x_d;
  logic [6:0]       y_q,     y_d;
  logic             act_q,   act_d;
  logic             hit_q,   hit_d;
  logic             bot_q,   bot_d;

  // Datapath terms shared by the next-state logic.
  logic [7:0] spawn_y;
  logic [7:0] next_y;
  logic [8:0] next_y_9;
  logic [8:0] x_9;
  logic [8:0] px_9;
  logic       y_in_box;
  logic       x_in_box;
  logic       hit_now;
  logic       off_bottom;
  logic       spawn_off;
  logic [7:0] aim_x;

  // Spawn row, next flight row and the hitbox / bottom tests, all sized to
  // avoid wrap in the compares.
  always_comb begin
    spawn_y    = {1'b0, enemyY} + SPAWN_OFS;
    next_y     = {1'b0, y_q} + STEP_8;
    next_y_9   = {1'b0, next_y};
    x_9        = {1'b0, x_q};
    px_9       = {1'b0, playerX};
    // Both upper bounds are exclusive: a bullet at playerX+HIT_W is a miss.
    y_in_box   = (next_y_9 >= BOX_TOP_9) && (next_y_9 < BOX_BOT_9);
    x_in_box   = (x_9 >= px_9) && (x_9 < (px_9 + HIT_W_9));
    hit_now    = y_in_box && x_in_box;
    off_bottom = (next_y > Y_BOT_8);
    spawn_off  = (spawn_y > Y_BOT_8);
  end

  // Column for the next flight tick; the hit test above uses the current one.
  always_comb begin
    aim_x = x_q;
`ifdef ENEMY_BULLET_AIM_EN
    if (x_q < playerX) begin
      aim_x = x_q + 8'd1;
    end else if (x_q > playerX) begin
      aim_x = x_q - 8'd1;
    end
`else
    aim_x = x_q;
`endif
  end

  // Next-state and registered-output logic for the IDLE / COOL / FLIGHT FSM.
  always_comb begin
    // NOTE: every variable gets a default here so no path can leave one
    // unassigned; otherwise synthesis would infer a latch to hold it.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    act_d   = act_q;
    hit_d   = 1'b0;
    bot_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          cnt_d   = CNT_RELOAD;
          state_d = S_COOL;
        end
      end

      S_COOL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (spawn_off) begin
            // Enemy too low to spawn a visible bullet: wait another period.
            cnt_d = CNT_RELOAD;
          end else begin
            x_d     = enemyX;
            y_d     = spawn_y[6:0];
            act_d   = 1'b1;
            state_d = S_FLIGHT;
          end
        end
      end

      S_FLIGHT: begin
        // enable is ignored here: a bullet in flight always finishes.
        if (tick) begin
          x_d = aim_x;
          if (hit_now || off_bottom) begin
            // Hit outranks bottom, so the two pulses are mutually exclusive.
            hit_d   = hit_now;
            bot_d   = !hit_now;
            act_d   = 1'b0;
            if (enable) begin
              cnt_d   = CNT_RELOAD;
              state_d = S_COOL;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            y_d = next_y[6:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      hit_q   <= 1'b0;
      bot_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      bot_q   <= bot_d;
    end
  end

  assign bulletX       = x_q;
  assign bulletY       = y_q;
  assign active        = act_q;
  assign playerHit     = hit_q;
  assign bottomReached = bot_q;

endmodule

// File: tb/tb_enemy_bullet_ctrl.sv
// Self-checking bench for enemy_bullet_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the bullet.

module tb_enemy_bullet_ctrl;

  localparam int STEP     = 4;
  localparam int PLAYER_Y = 100;
  localparam int HIT_W    = 8;
  localparam int HIT_H    = 8;
  localparam int Y_BOTTOM = 119;
  localparam int COOLDOWN = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tick;
  logic       enable;
  logic [7:0] enemyX;
  logic [6:0] enemyY;
  logic [7:0] playerX;
  logic [7:0] bulletX;
  logic [6:0] bulletY;
  logic       active;
  logic       playerHit;
  logic       bottomReached;

  int tests = 0;
  int fails = 0;

  enemy_bullet_ctrl #(
    .STEP(STEP), .PLAYER_Y(PLAYER_Y), .HIT_W(HIT_W), .HIT_H(HIT_H),
    .Y_BOTTOM(Y_BOTTOM), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .enable(enable),
    .enemyX(enemyX), .enemyY(enemyY), .playerX(playerX),
    .bulletX(bulletX), .bulletY(bulletY), .active(active),
    .playerHit(playerHit), .bottomReached(bottomReached)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A bullet is either flying, or the launcher is waiting out a number of
  // ticks before its next launch attempt, or the launcher is disarmed.
  bit m_flying = 0;
  bit m_armed  = 0;
  int m_wait   = 0;
  int m_x      = 0;
  int m_y      = 0;
  bit m_act    = 0;
  bit m_hit    = 0;
  bit m_bot    = 0;

  always @(posedge clk or negedge resetn) begin : model
    int  ny;
    bit  struck;
    if (!resetn) begin
      m_flying = 0; m_armed = 0; m_wait = 0;
      m_x = 0; m_y = 0; m_act = 0; m_hit = 0; m_bot = 0;
    end else begin
      m_hit = 0;
      m_bot = 0;
      if (m_flying) begin
        if (tick) begin
          ny     = m_y + STEP;
          struck = (ny >= PLAYER_Y) && (ny < PLAYER_Y + HIT_H) &&
                   (m_x >= int'(playerX)) && (m_x < int'(playerX) + HIT_W);
`ifdef ENEMY_BULLET_AIM_EN
          if (m_x < int'(playerX)) m_x = m_x + 1;
          else if (m_x > int'(playerX)) m_x = m_x - 1;
`endif
          if (struck || ny > Y_BOTTOM) begin
            m_hit    = struck;
            m_bot    = !struck;
            m_act    = 0;
            m_flying = 0;
            m_armed  = enable;
            m_wait   = COOLDOWN;
          end else begin
            m_y = ny;
          end
        end
      end else if (!m_armed) begin
        if (enable) begin
          m_armed = 1;
          m_wait  = COOLDOWN;
        end
      end else if (!enable) begin
        m_armed = 0;
      end else if (tick) begin
        if (m_wait > 0) begin
          m_wait = m_wait - 1;
        end else if (int'(enemyY) + 8 > Y_BOTTOM) begin
          m_wait = COOLDOWN;
        end else begin
          m_x      = enemyX;
          m_y      = int'(enemyY) + 8;
          m_act    = 1;
          m_flying = 1;
          m_armed  = 0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      check("bulletX_vs_model",       32'(bulletX),       32'(m_x));
      check("bulletY_vs_model",       32'(bulletY),       32'(m_y));
      check("active_vs_model",        32'(active),        32'(m_act));
      check("playerHit_vs_model",     32'(playerHit),     32'(m_hit));
      check("bottomReached_vs_model", 32'(bottomReached), 32'(m_bot));
    end
  end

  // One tick strobe, one clock wide; returns at the negedge after it was sampled.
  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    resetn  = 1'b0;
    tick    = 1'b0;
    enable  = 1'b0;
    enemyX  = 8'd0;
    enemyY  = 7'd0;
    playerX = 8'd0;

    repeat (2) @(negedge clk);
    check("reset_bulletX", 32'(bulletX), 32'd0);
    check("reset_bulletY", 32'(bulletY), 32'd0);
    check("reset_active",  32'(active),  32'd0);
    check("reset_pulses",  32'({playerHit, bottomReached}), 32'd0);
    resetn = 1'b1;

    // Fire: three ticks in COOL with COOLDOWN=2.
    enable = 1'b1; enemyX = 8'd40; enemyY = 7'd10; playerX = 8'd100;
    do_ticks(2);
    check("fire_not_before_3rd_tick", 32'(active), 32'd0);
    do_tick();
    check("fire_bulletX", 32'(bulletX), 32'd40);
    check("fire_bulletY", 32'(bulletY), 32'd18);
    check("fire_active",  32'(active),  32'd1);

    // Miss: 25 steps to row 118, then the bottom event.
    do_ticks(25);
    check("miss_row_118",    32'(bulletY), 32'd118);
    check("miss_still_live", 32'(active),  32'd1);
    do_tick();
    check("miss_bottom_pulse", 32'(bottomReached), 32'd1);
    check("miss_no_hit",       32'(playerHit),     32'd0);
    check("miss_active_low",   32'(active),        32'd0);
    check("miss_y_held",       32'(bulletY),       32'd118);
    @(negedge clk);
    check("miss_pulse_one_cycle", 32'(bottomReached), 32'd0);

    // Hit: cooldown reloaded to 2, so the third tick fires again.
    playerX = 8'd36;
    do_ticks(2);
    check("reload_inactive", 32'(active), 32'd0);
    do_tick();
    check("refire_active", 32'(active), 32'd1);
    do_ticks(20);
    check("hit_row_98", 32'(bulletY), 32'd98);
    do_tick();
    check("hit_pulse",      32'(playerHit),     32'd1);
    check("hit_no_bottom",  32'(bottomReached), 32'd0);
    check("hit_active_low", 32'(active),        32'd0);
    check("hit_y_held",     32'(bulletY),       32'd98);
    @(negedge clk);
    check("hit_pulse_one_cycle", 32'(playerHit), 32'd0);

    // Hitbox right edge is exclusive: bulletX = playerX + HIT_W misses.
    playerX = 8'd32;
    do_ticks(3);
    check("edge_fired", 32'(active), 32'd1);
    do_ticks(25);
`ifndef ENEMY_BULLET_AIM_EN
    do_tick();
    check("edge_no_hit",       32'(playerHit),     32'd0);
    check("edge_bottom_pulse", 32'(bottomReached), 32'd1);
`else
    do_ticks(2);
`endif
    check("edge_active_low", 32'(active), 32'd0);

    // Spawn off-screen: 115+8 = 123 > 119, no fire and cooldown reloads.
    enemyY = 7'd115;
    @(negedge clk);
    do_ticks(3);
    check("offscreen_no_fire", 32'(active), 32'd0);
    do_ticks(2);
    check("offscreen_still_idle", 32'(active), 32'd0);
    enemyY = 7'd10;
    do_tick();
    check("after_reload_fire", 32'(active),  32'd1);
    check("after_reload_y",    32'(bulletY), 32'd18);

    // Asynchronous reset mid-flight, well away from any clock edge.
    do_ticks(3);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_active",  32'(active),  32'd0);
    check("async_rst_bulletX", 32'(bulletX), 32'd0);
    check("async_rst_bulletY", 32'(bulletY), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      enemyX  = ($urandom_range(0, 9) < 6) ? 8'($urandom_range(30, 50)) : 8'($urandom_range(0, 159));
      enemyY  = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(105, 119)) : 7'($urandom_range(0, 60));
      playerX = ($urandom_range(0, 9) < 6) ? 8'($urandom_range(25, 55)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 799) == 0) begin
        #2 resetn = 1'b0;
        #1;
        check("rand_async_rst", 32'({bulletX, bulletY, active, playerHit, bottomReached}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_ctrl.md
# enemy_bullet_ctrl

Enemy-side counterpart of the player bullet datapath: fires a single bullet downward from an enemy position, advances it one step per frame tick, and checks it against the player hitbox. It sits between the enemy position logic and the VGA draw FSM, which reads `bulletX`/`bulletY`/`active`. Hit and miss events go to the game-state/lives logic.

## Interface
- `STEP`, 4: downward pixels per tick; must be ≤ `HIT_H` so the bullet cannot skip over the hitbox.
- `PLAYER_Y`, 100: top row of the player hitbox.
- `HIT_W`, 8: hitbox width in pixels.
- `HIT_H`, 8: hitbox height in pixels.
- `Y_BOTTOM`, 119: last visible row.
- `COOLDOWN`, 30: ticks between the end of one bullet and the next fire.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle frame strobe; each cycle it is high counts as one step.
- `enable`  in  1  firing permitted.
- `enemyX`  in  8  enemy X, 0–159.
- `enemyY`  in  7  enemy Y, 0–119.
- `playerX`  in  8  left column of the player hitbox.
- `bulletX`  out  8  bullet X, registered.
- `bulletY`  out  7  bullet Y, registered.
- `active`  out  1  bullet is in flight and should be drawn.
- `playerHit`  out  1  one-cycle pulse when the bullet hits the player.
- `bottomReached`  out  1  one-cycle pulse when the bullet leaves the screen.

## Operation
- Reset (async): state IDLE; `bulletX`=0, `bulletY`=0, `active`=0, `playerHit`=0, `bottomReached`=0; cooldown count `cnt`=0.
- IDLE: when `enable`=1, load `cnt`=`COOLDOWN` and go to COOL.
- COOL:
  - `enable`=0: go to IDLE.
  - Otherwise, on `tick` with `cnt`≠0: decrement `cnt`.
  - Otherwise, on `tick` with `cnt`=0: compute `sy = enemyY + 8` at 8 bits.
    - `sy` > `Y_BOTTOM`: do not fire; reload `cnt`, stay in COOL.
    - Otherwise: latch `bulletX`=`enemyX`, `bulletY`=`sy`, set `active`=1, go to FLIGHT.
- FLIGHT, on `tick`: compute `ny = bulletY + STEP` at 8 bits.
  - Hit test, all compares at 9 bits: `ny` ≥ `PLAYER_Y`, `ny` < `PLAYER_Y+HIT_H`, `bulletX` ≥ `playerX`, `bulletX` < `playerX+HIT_W`. Both upper bounds are exclusive.
  - Hit: pulse `playerHit`; `active`=0; `bulletY` unchanged.
  - Else `ny` > `Y_BOTTOM`: pulse `bottomReached`; `active`=0; `bulletY` unchanged.
  - Else: `bulletY`=`ny`[6:0].
  - A hit takes priority over bottom when both conditions hold.
  - After a hit or bottom event: if `enable`=1, reload `cnt` and go to COOL; otherwise go to IDLE.
- `enable` falling during FLIGHT does not abort; the bullet finishes its flight.
- When inactive, `bulletX`/`bulletY` hold their last values.

## Timing
- All outputs are registered; effects appear one `clk` after the `tick` cycle.
- `playerHit` and `bottomReached` are high for exactly one `clk` cycle and are never both high in the same cycle.
- Fire latency from entering COOL: `COOLDOWN`+1 ticks.
- `active` rises in the same cycle that `bulletX`/`bulletY` are loaded.
- `active` falls in the same cycle as the event pulse.
- `resetn` asserted mid-flight: outputs clear immediately, without waiting for `clk`; a pending pulse is dropped.

## Configuration
- `ENEMY_BULLET_AIM_EN` defined: on every FLIGHT tick, `bulletX` moves 1 toward `playerX` (+1 if less, −1 if greater, unchanged if equal). The hit test uses the pre-update `bulletX`.
- Not defined: `bulletX` is fixed for the whole flight.

## Test plan
- Reset mid-flight: assert `resetn`=0 while `active`=1 → all outputs 0 without a `clk` edge; state IDLE.
- Fire: `COOLDOWN`=2, `enable`=1, `enemyX`=40, `enemyY`=10 → after the 3rd tick in COOL, `bulletX`=40, `bulletY`=18, `active`=1.
- Miss: as the fire test with `playerX`=100 → Y steps 18, 22, …, 118; the next tick gives `bottomReached` pulse, `active`=0, `bulletY`=118; `cnt` reloads to 2.
- Hit: `playerX`=36, bullet at X 40 → at the tick where `ny`=102, `playerHit` pulses; `bulletY` stays 98; `active`=0.
- Hitbox edge: `playerX`=32, `bulletX`=40 (= `playerX+8`) → no hit; `bottomReached` pulses at the end of flight.
- Spawn off-screen: `enemyY`=115 → `sy`=123 > 119; no fire, `active` stays 0, cooldown reloads. With `ENEMY_BULLET_AIM_EN`, `bulletX`=40 and `playerX`=44 → `bulletX` goes 41, 42, 43, 44, then holds.
